// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types and March C- element tables for the SRAM BIST engine.
package sram_bist_pkg;

    // March C- element index
    typedef enum logic [2:0] {
        E0, E1, E2, E3, E4, E5
    } elem_t;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE, RUN, DRAIN, DONE
    } state_t;

    // Per-element tables, bit i describes element Ei. Bits 6-7 are padding so
    // any 3-bit element index selects a defined bit.
    localparam logic [7:0] C_DIR_DOWN = 8'b0001_1000;  // E3, E4 count down
    localparam logic [7:0] C_HAS_RD   = 8'b0011_1110;  // E1..E5 start with a read
    localparam logic [7:0] C_HAS_WR   = 8'b0001_1111;  // E0..E4 contain a write
    localparam logic [7:0] C_RD_POL   = 8'b0001_0100;  // E2, E4 read ones
    localparam logic [7:0] C_WR_POL   = 8'b0000_1010;  // E1, E3 write ones

endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp: one-cycle read-compare and first-failure capture stage.
// Optional macro BIST_ERR_CNT_EN adds a saturating 16-bit miscompare counter.
module sram_bist_cmp #(
    parameter int P_ADDR_WIDTH = 13,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_rd_vld,
    input  logic [P_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] i_rd_exp,
    input  logic [P_DATA_WIDTH-1:0] i_dout,
    output logic                    o_miscmp,
    output logic                    o_fail,
    output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
    output logic [P_DATA_WIDTH-1:0] o_fail_exp,
    output logic [P_DATA_WIDTH-1:0] o_fail_got
`ifdef BIST_ERR_CNT_EN
    ,
    output logic [15:0]             o_err_cnt
`endif
);

    logic                    r_vld;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_DATA_WIDTH-1:0] r_exp;
    logic                    r_fail;
    logic [P_ADDR_WIDTH-1:0] r_fail_addr;
    logic [P_DATA_WIDTH-1:0] r_fail_exp;
    logic [P_DATA_WIDTH-1:0] r_fail_got;
    logic                    w_miscmp;

    // Register the issued read so its data can be checked one edge later
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_exp  <= '0;
        end else begin
            r_vld  <= i_rd_vld;
            r_addr <= i_rd_addr;
            r_exp  <= i_rd_exp;
        end
    end

    assign w_miscmp = r_vld && (i_dout != r_exp);

    // Capture the first miscompare and hold it until the next start
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else if (i_clr) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else if (w_miscmp && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_exp  <= r_exp;
            r_fail_got  <= i_dout;
        end
    end

`ifdef BIST_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Count every miscompare, saturating at all ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (i_clr) begin
            r_err_cnt <= '0;
        end else if (w_miscmp && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_miscmp    = w_miscmp;
    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_exp  = r_fail_exp;
    assign o_fail_got  = r_fail_got;

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// sram_bist_march_ctrl: March C- BIST controller driving the SRAM BIST port.
// One macro operation per cycle, 10N operations per run. Optional macro
// BIST_ERR_CNT_EN adds BIST_ERR_CNT and runs to completion despite failures.
module sram_bist_march_ctrl
    import sram_bist_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 13,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    BIST_START,
    output logic                    BIST_BUSY,
    output logic                    BIST_DONE,
    output logic                    BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
    output logic [P_DATA_WIDTH-1:0] BIST_FAIL_EXP,
    output logic [P_DATA_WIDTH-1:0] BIST_FAIL_GOT,
`ifdef BIST_ERR_CNT_EN
    output logic [15:0]             BIST_ERR_CNT,
`endif
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_MAX = '1;
    localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_ONE = P_ADDR_WIDTH'(1);
`ifdef BIST_ERR_CNT_EN
    localparam logic C_ABORT_ON_FAIL = 1'b0;
`else
    localparam logic C_ABORT_ON_FAIL = 1'b1;
`endif

    state_t                  r_state;
    elem_t                   r_elem;
    logic                    r_op;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_men;
    logic                    r_wen;
    logic                    r_ren;
    logic                    r_din;
    logic                    r_rd_pol;

    elem_t                   w_nxt_elem;
    logic                    w_nxt_op;
    logic [P_ADDR_WIDTH-1:0] w_nxt_addr;
    logic                    w_nxt_rd;
    logic                    w_nxt_wr;
    logic                    w_addr_end;
    logic                    w_last;
    logic                    w_start;
    logic                    w_miscmp;
    logic                    w_abort;

    assign w_start = BIST_START && ((r_state == IDLE) || (r_state == DONE));
    assign w_abort = w_miscmp && C_ABORT_ON_FAIL;

    // Work out the operation that follows the one currently on the macro port
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it
        // unassigned, which would infer a latch.
        w_nxt_elem = r_elem;
        w_nxt_op   = 1'b0;
        w_nxt_addr = r_addr;
        w_addr_end = C_DIR_DOWN[r_elem] ? (r_addr == '0) : (r_addr == C_ADDR_MAX);
        if (C_HAS_RD[r_elem] && C_HAS_WR[r_elem] && !r_op) begin
            w_nxt_op = 1'b1;
        end else if (w_addr_end) begin
            w_nxt_elem = elem_t'(r_elem + 3'd1);
            w_nxt_addr = C_DIR_DOWN[w_nxt_elem] ? C_ADDR_MAX : '0;
        end else if (C_DIR_DOWN[r_elem]) begin
            w_nxt_addr = r_addr - C_ADDR_ONE;
        end else begin
            w_nxt_addr = r_addr + C_ADDR_ONE;
        end
        w_last   = (r_elem == E5) && w_addr_end;
        w_nxt_rd = C_HAS_RD[w_nxt_elem] && !w_nxt_op;
        w_nxt_wr = C_HAS_WR[w_nxt_elem] && (w_nxt_op || !C_HAS_RD[w_nxt_elem]);
    end

    // Controller FSM with registered macro-port outputs
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            r_state  <= IDLE;
            r_elem   <= E0;
            r_op     <= 1'b0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_men    <= 1'b0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_din    <= 1'b0;
            r_rd_pol <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (BIST_START) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_elem   <= E0;
                        r_op     <= 1'b0;
                        r_addr   <= '0;
                        r_men    <= 1'b1;
                        r_wen    <= C_HAS_WR[E0];
                        r_ren    <= 1'b0;
                        r_din    <= C_WR_POL[E0];
                        r_rd_pol <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_abort || w_last) begin
                        r_state  <= w_abort ? DONE : DRAIN;
                        r_busy   <= !w_abort;
                        r_done   <= w_abort;
                        r_addr   <= '0;
                        r_men    <= 1'b0;
                        r_wen    <= 1'b0;
                        r_ren    <= 1'b0;
                        r_din    <= 1'b0;
                        r_rd_pol <= 1'b0;
                    end else begin
                        r_elem   <= w_nxt_elem;
                        r_op     <= w_nxt_op;
                        r_addr   <= w_nxt_addr;
                        r_men    <= 1'b1;
                        r_wen    <= w_nxt_wr;
                        r_ren    <= w_nxt_rd;
                        r_din    <= w_nxt_wr && C_WR_POL[w_nxt_elem];
                        r_rd_pol <= C_RD_POL[w_nxt_elem];
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    sram_bist_cmp #(
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_cmp (
        .i_clk       (A_CLK),
        .i_rst       (A_RST),
        .i_clr       (w_start),
        .i_rd_vld    (r_ren),
        .i_rd_addr   (r_addr),
        .i_rd_exp    ({P_DATA_WIDTH{r_rd_pol}}),
        .i_dout      (A_DOUT),
        .o_miscmp    (w_miscmp),
        .o_fail      (BIST_FAIL),
        .o_fail_addr (BIST_FAIL_ADDR),
        .o_fail_exp  (BIST_FAIL_EXP),
        .o_fail_got  (BIST_FAIL_GOT)
`ifdef BIST_ERR_CNT_EN
        ,
        .o_err_cnt   (BIST_ERR_CNT)
`endif
    );

    assign BIST_BUSY   = r_busy;
    assign BIST_DONE   = r_done;
    assign A_BIST_EN   = r_busy;
    assign A_BIST_MEN  = r_men;
    assign A_BIST_WEN  = r_wen;
    assign A_BIST_REN  = r_ren;
    assign A_BIST_ADDR = r_addr;
    assign A_BIST_DIN  = {P_DATA_WIDTH{r_din}};
    assign A_BIST_BM   = {P_DATA_WIDTH{r_wen}};

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// tb_sram_bist_march_ctrl: directed bench for the March C- BIST controller
// with a 16-word behavioural SRAM and selectable fault injection.
// Define BIST_ERR_CNT_EN to exercise the error-counter build.
`timescale 1ns/1ps
module tb_sram_bist_march_ctrl;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int N    = 16;
    localparam int NOPS = 10 * N;

    logic          A_CLK      = 1'b0;
    logic          A_RST      = 1'b1;
    logic          BIST_START = 1'b0;
    logic          BIST_BUSY;
    logic          BIST_DONE;
    logic          BIST_FAIL;
    logic [AW-1:0] BIST_FAIL_ADDR;
    logic [DW-1:0] BIST_FAIL_EXP;
    logic [DW-1:0] BIST_FAIL_GOT;
`ifdef BIST_ERR_CNT_EN
    logic [15:0]   BIST_ERR_CNT;
`endif
    logic          A_BIST_EN;
    logic          A_BIST_MEN;
    logic          A_BIST_WEN;
    logic          A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN;
    logic [DW-1:0] A_BIST_BM;
    logic [DW-1:0] A_DOUT = '0;

    logic [DW-1:0] mem [N];
    int            fault_mode = 0;   // 0 none, 1 word 5 bit 7 stuck at 0, 2 word 3 reads 0
    int            n_vec = 0;
    int            n_err = 0;

    logic          e_wen  [NOPS];
    logic          e_ren  [NOPS];
    logic [AW-1:0] e_addr [NOPS];
    logic [DW-1:0] e_din  [NOPS];

    sram_bist_march_ctrl #(
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (DW)
    ) dut (
        .A_CLK          (A_CLK),
        .A_RST          (A_RST),
        .BIST_START     (BIST_START),
        .BIST_BUSY      (BIST_BUSY),
        .BIST_DONE      (BIST_DONE),
        .BIST_FAIL      (BIST_FAIL),
        .BIST_FAIL_ADDR (BIST_FAIL_ADDR),
        .BIST_FAIL_EXP  (BIST_FAIL_EXP),
        .BIST_FAIL_GOT  (BIST_FAIL_GOT),
`ifdef BIST_ERR_CNT_EN
        .BIST_ERR_CNT   (BIST_ERR_CNT),
`endif
        .A_BIST_EN      (A_BIST_EN),
        .A_BIST_MEN     (A_BIST_MEN),
        .A_BIST_WEN     (A_BIST_WEN),
        .A_BIST_REN     (A_BIST_REN),
        .A_BIST_ADDR    (A_BIST_ADDR),
        .A_BIST_DIN     (A_BIST_DIN),
        .A_BIST_BM      (A_BIST_BM),
        .A_DOUT         (A_DOUT)
    );

    always #5 A_CLK = ~A_CLK;

    function automatic logic [DW-1:0] faulty_read(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = mem[a];
        if (fault_mode == 1 && a == 4'd5) w[7] = 1'b0;
        if (fault_mode == 2 && a == 4'd3) w = '0;
        return w;
    endfunction

    // Behavioural SRAM: bit-masked write, read data valid the cycle after the read edge
    always @(posedge A_CLK) begin
        if (A_BIST_EN && A_BIST_MEN && A_BIST_WEN)
            mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
        if (A_BIST_EN && A_BIST_MEN && A_BIST_REN)
            A_DOUT <= faulty_read(A_BIST_ADDR);
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    // Expected March C- operation list, written straight from the element table
    task automatic build_ops();
        int k;
        logic [AW-1:0] a;
        k = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
                if (e >= 1) begin
                    e_wen[k] = 1'b0; e_ren[k] = 1'b1; e_addr[k] = a; e_din[k] = '0;
                    k++;
                end
                if (e <= 4) begin
                    e_wen[k] = 1'b1; e_ren[k] = 1'b0; e_addr[k] = a;
                    e_din[k] = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
                    k++;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"},
              {BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, BIST_FAIL_EXP, BIST_FAIL_GOT}, '0);
        check({tag, "_port"},
              {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM}, '0);
`ifdef BIST_ERR_CNT_EN
        check({tag, "_errcnt"}, BIST_ERR_CNT, '0);
`endif
    endtask

    // Start a run and check the first n issued operations; optionally pulse
    // BIST_START again during cycle restart_at
    task automatic run_seq(input int n, input int restart_at);
        BIST_START = 1'b1;
        tick();
        BIST_START = 1'b0;
        check("start_clear",
              {BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, BIST_FAIL_EXP, BIST_FAIL_GOT}, '0);
`ifdef BIST_ERR_CNT_EN
        check("start_errcnt", BIST_ERR_CNT, '0);
`endif
        for (int k = 0; k < n; k++) begin
            check($sformatf("op%0d", k),
                  {BIST_BUSY, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                   A_BIST_ADDR, A_BIST_DIN, A_BIST_BM},
                  {1'b1, 1'b1, 1'b1, e_wen[k], e_ren[k], e_addr[k], e_din[k], {DW{e_wen[k]}}});
            BIST_START = (k == restart_at);
            tick();
            BIST_START = 1'b0;
        end
    endtask

    // After a full run: one DRAIN cycle, then DONE with the given fail state
    task automatic finish_run(input string tag, input logic fail);
        check({tag, "_drain"},
              {BIST_BUSY, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, BIST_DONE},
              6'b110000);
        tick();
        check({tag, "_done"},
              {BIST_BUSY, A_BIST_EN, A_BIST_MEN, BIST_DONE, BIST_FAIL, A_BIST_BM},
              {4'b0001, fail, {DW{1'b0}}});
        tick();
        check({tag, "_sticky"}, {BIST_BUSY, BIST_DONE, BIST_FAIL}, {2'b01, fail});
    endtask

    initial begin
        build_ops();

        // Reset state
        repeat (3) @(posedge A_CLK);
        #1;
        check_all_zero("reset");
        @(negedge A_CLK);
        A_RST = 1'b0;
        tick();
        check_all_zero("idle");

        // Clean pass: 160 issue cycles, DONE on cycle 161
        fault_mode = 0;
        run_seq(NOPS, -1);
        finish_run("clean", 1'b0);
`ifdef BIST_ERR_CNT_EN
        check("clean_errcnt", BIST_ERR_CNT, 16'd0);
`endif

        // Start pulse during RUN is ignored
        run_seq(NOPS, 20);
        finish_run("restart_ignored", 1'b0);

        // Word 5 bit 7 stuck at 0: first caught by the E2 read of word 5
        fault_mode = 1;
`ifndef BIST_ERR_CNT_EN
        run_seq(60, -1);
        check("sa0_stop", {BIST_BUSY, A_BIST_EN, A_BIST_MEN, BIST_DONE, BIST_FAIL}, 5'b00011);
        check("sa0_addr", BIST_FAIL_ADDR, 4'd5);
        check("sa0_exp", BIST_FAIL_EXP, 32'hFFFF_FFFF);
        check("sa0_got", BIST_FAIL_GOT, 32'hFFFF_FF7F);
        repeat (3) tick();
        check("sa0_frozen",
              {A_BIST_MEN, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, BIST_FAIL_GOT},
              {4'b0011, 4'd5, 32'hFFFF_FF7F});
`else
        run_seq(NOPS, -1);
        finish_run("sa0", 1'b1);
        check("sa0_errcnt", BIST_ERR_CNT, 16'd2);
        check("sa0_addr", BIST_FAIL_ADDR, 4'd5);
        check("sa0_exp", BIST_FAIL_EXP, 32'hFFFF_FFFF);
        check("sa0_got", BIST_FAIL_GOT, 32'hFFFF_FF7F);
`endif

        // Start from DONE clears the flags and runs a clean pass
        fault_mode = 0;
        run_seq(NOPS, -1);
        finish_run("rerun", 1'b0);

        // Reset mid-run: outputs drop in the same cycle, then a clean pass
        run_seq(40, -1);
        #2;
        A_RST = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge A_CLK);
        A_RST = 1'b0;
        tick();
        run_seq(NOPS, -1);
        finish_run("after_rst", 1'b0);

`ifdef BIST_ERR_CNT_EN
        // Word 3 always reads 0: the ones-reads in E2 and E4 miscompare
        fault_mode = 2;
        run_seq(NOPS, -1);
        finish_run("w3zero", 1'b1);
        check("w3zero_errcnt", BIST_ERR_CNT, 16'd2);
        check("w3zero_addr", BIST_FAIL_ADDR, 4'd3);
        check("w3zero_exp", BIST_FAIL_EXP, 32'hFFFF_FFFF);
        check("w3zero_got", BIST_FAIL_GOT, 32'h0000_0000);
        fault_mode = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
